// File: rtl/program_loader.sv
// program_loader
//   Writer side of the CPU instruction memory. Consumes a byte stream
//   HDR(N), N x (HI, LO), CSUM and writes N 15-bit words {opcode, literal}
//   to consecutive instruction memory addresses starting at BASE_ADDR.
//   The CPU is held (cpu_hold=1) until a complete image with a matching
//   XOR checksum has been written.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input byte valid
//   in_ready   out  loader can accept a byte
//   in_data    in   input byte
//   start      in   one-cycle pulse, re-arms the loader from DONE or ERR
//   im_we      out  instruction memory write enable (one-cycle pulse)
//   im_addr    out  instruction memory write address
//   im_wdata   out  instruction word {opcode[6:0], literal[7:0]}
//   cpu_hold   out  high while the CPU must not execute
//   done       out  image loaded and verified
//   error      out  protocol or checksum failure
//   dbg_state  out  current FSM state encoding (observation only)
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is a registered function of the state and never
// depends on in_valid; in_data is ignored while in_valid is low.
module program_loader #(
  parameter int              ADDR_W    = 8,
  parameter int              INSTR_W   = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               start,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           count_q, count_d;
  logic [7:0]           acc_q, acc_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [6:0]           opcode_q, opcode_d;
  logic                 im_we_q, im_we_d;
  logic [INSTR_W-1:0]   im_wdata_q, im_wdata_d;
  logic                 in_ready_q, in_ready_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    opcode_d   = opcode_q;
    im_we_d    = 1'b0;
    im_wdata_d = im_wdata_q;

    // The address advances on the edge that commits the write, so im_addr
    // shows the target address for the whole cycle im_we is high.
    if (im_we_q) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (in_data == 8'd0) begin
            state_d = S_ERR;
          end else begin
            count_d = in_data;
            acc_d   = in_data;
            addr_d  = BASE_ADDR;
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          if (in_data[7]) begin
            state_d = S_ERR;
          end else begin
            opcode_d = in_data[6:0];
            acc_d    = acc_q ^ in_data;
            state_d  = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          acc_d      = acc_q ^ in_data;
          count_d    = count_q - 8'd1;
          im_we_d    = 1'b1;
          im_wdata_d = INSTR_W'({opcode_q, in_data});
          // count_q is the value before this pair is retired.
          state_d    = (count_q != 8'd1) ? S_HI : S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == acc_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          acc_d   = 8'd0;
          state_d = S_HDR;
        end
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    // Status outputs are registered copies of the next state so they are
    // glitch-free and line up with the state register.
    in_ready_d = (state_d == S_HDR) || (state_d == S_HI) ||
                 (state_d == S_LO)  || (state_d == S_CSUM);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      count_q    <= 8'd0;
      acc_q      <= 8'd0;
      addr_q     <= BASE_ADDR;
      opcode_q   <= 7'd0;
      im_we_q    <= 1'b0;
      im_wdata_q <= '0;
      in_ready_q <= 1'b1;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      opcode_q   <= opcode_d;
      im_we_q    <= im_we_d;
      im_wdata_q <= im_wdata_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = im_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. Instance u_dut_a uses BASE_ADDR=0,
// instance u_dut_b uses BASE_ADDR=254 for the address wrap case.
module tb_program_loader;

  localparam int WR_W = 8 + 15;
  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_HI   = 3'd1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_valid_b, start;
  logic [7:0]  in_data;
  logic        in_ready, im_we, cpu_hold, done, error;
  logic [7:0]  im_addr;
  logic [14:0] im_wdata;
  logic [2:0]  dbg_state;
  logic        in_ready_b, im_we_b, cpu_hold_b, done_b, error_b;
  logic [7:0]  im_addr_b;
  logic [14:0] im_wdata_b;
  logic [2:0]  dbg_state_b;

  program_loader #(.ADDR_W(8), .INSTR_W(15), .BASE_ADDR(8'd0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  program_loader #(.ADDR_W(8), .INSTR_W(15), .BASE_ADDR(8'd254)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .start(start), .im_we(im_we_b), .im_addr(im_addr_b),
    .im_wdata(im_wdata_b), .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b),
    .dbg_state(dbg_state_b)
  );

  // scoreboard
  logic [WR_W-1:0] exp_q_a[$];
  logic [WR_W-1:0] exp_q_b[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] op_m[16];
  logic [7:0] lit_m[16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // write monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        check_eq("write_a_pending", exp_q_a.size(), 1);
      end else begin
        check_eq("write_a", {im_addr, im_wdata}, exp_q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (im_we_b === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        check_eq("write_b_pending", exp_q_b.size(), 1);
      end else begin
        check_eq("write_b", {im_addr_b, im_wdata_b}, exp_q_b.pop_front());
      end
    end
  end

  // driver tasks
  task automatic idle(input bit gap);
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit expect_we);
    bit got;
    got = 1'b0;
    in_data = b;
    if (sel == 0) in_valid = 1'b1;
    else          in_valid_b = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if ((sel == 0) ? in_ready : in_ready_b) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    in_valid   = 1'b0;
    in_valid_b = 1'b0;
    if (!got) check_eq("ready_timeout", got, 1);
    else if (expect_we) check_eq("we_latency", (sel == 0) ? im_we : im_we_b, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_final(input int sel, input string tag, input bit exp_done);
    if (sel == 0) begin
      check_eq({tag, "_done"},  done, exp_done);
      check_eq({tag, "_error"}, error, !exp_done);
      check_eq({tag, "_hold"},  cpu_hold, !exp_done);
      check_eq({tag, "_ready"}, in_ready, 0);
      check_eq({tag, "_drain"}, exp_q_a.size(), 0);
    end else begin
      check_eq({tag, "_done"},  done_b, exp_done);
      check_eq({tag, "_error"}, error_b, !exp_done);
      check_eq({tag, "_hold"},  cpu_hold_b, !exp_done);
      check_eq({tag, "_ready"}, in_ready_b, 0);
      check_eq({tag, "_drain"}, exp_q_b.size(), 0);
    end
  endtask

  // Sends a full image from op_m/lit_m and queues the expected writes.
  task automatic run_stream(input int sel, input logic [7:0] base, input int n,
                            input bit bad, input bit gaps, input string tag);
    logic [7:0] acc, addr, hi;
    acc  = 8'(n);
    addr = base;
    send_byte(sel, 8'(n), 1'b0);
    idle(gaps);
    for (int i = 0; i < n; i++) begin
      hi = {1'b0, op_m[i]};
      if (sel == 0) exp_q_a.push_back({addr, op_m[i], lit_m[i]});
      else          exp_q_b.push_back({addr, op_m[i], lit_m[i]});
      acc = acc ^ hi ^ lit_m[i];
      send_byte(sel, hi, 1'b0);
      idle(gaps);
      send_byte(sel, lit_m[i], 1'b1);
      idle(gaps);
      addr = addr + 8'd1;
    end
    send_byte(sel, bad ? (acc ^ 8'h01) : acc, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_final(sel, tag, !bad);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, dbg_state, ST_HDR);
    check_eq({tag, "_ready"}, in_ready, 1);
    check_eq({tag, "_we"},    im_we, 0);
    check_eq({tag, "_addr"},  im_addr, 0);
    check_eq({tag, "_wdata"}, im_wdata, 0);
    check_eq({tag, "_hold"},  cpu_hold, 1);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_error"}, error, 0);
  endtask

  task automatic load_nominal();
    op_m[0] = 7'h01; lit_m[0] = 8'h05;
    op_m[1] = 7'h03; lit_m[1] = 8'hA0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; in_data = 8'h00; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    check_eq("reset_b_addr", im_addr_b, 8'd254);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // nominal load: 0x0105 @0, 0x03A0 @1, CSUM 0xA5
    load_nominal();
    run_stream(0, 8'd0, 2, 1'b0, 1'b0, "nominal");
    check_eq("nominal_addr_after", im_addr, 8'd2);

    // start and in_valid together in DONE: byte must not be consumed
    in_valid = 1'b1; in_data = 8'h02;
    pulse_start();
    in_valid = 1'b0;
    check_eq("restart_state", dbg_state, ST_HDR);
    check_eq("restart_done", done, 0);
    check_eq("restart_hold", cpu_hold, 1);
    check_eq("restart_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check_eq("restart_state_held", dbg_state, ST_HDR);

    // bad checksum: both words still written
    run_stream(0, 8'd0, 2, 1'b1, 1'b0, "badcsum");
    pulse_start();
    check_eq("badcsum_rearm_error", error, 0);

    // illegal HI byte
    send_byte(0, 8'h01, 1'b0);
    send_byte(0, 8'h80, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_final(0, "illegal_hi", 1'b0);
    pulse_start();
    check_eq("illegal_hi_rearm_state", dbg_state, ST_HDR);
    check_eq("illegal_hi_rearm_error", error, 0);

    // start ignored mid-stream
    send_byte(0, 8'h01, 1'b0);
    pulse_start();
    check_eq("start_ignored_state", dbg_state, ST_HI);
    rst_n = 1'b0;
    #2;
    check_reset_vals("abandon_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // nominal stream with an idle cycle between every byte
    run_stream(0, 8'd0, 2, 1'b0, 1'b1, "gaps");
    pulse_start();

    // reset after the first LO handshake, before the write edge
    send_byte(0, 8'h02, 1'b0);
    send_byte(0, 8'h01, 1'b0);
    send_byte(0, 8'h05, 1'b1);
    rst_n = 1'b0;
    #2;
    check_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midreset_drain", exp_q_a.size(), 0);
    run_stream(0, 8'd0, 2, 1'b0, 1'b0, "after_reset");
    pulse_start();

    // zero count header
    send_byte(0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_final(0, "zero_hdr", 1'b0);
    pulse_start();

    // address wrap on the BASE_ADDR=254 instance: 254, 255, 0
    op_m[0] = 7'h11; lit_m[0] = 8'h22;
    op_m[1] = 7'h7F; lit_m[1] = 8'hFF;
    op_m[2] = 7'h00; lit_m[2] = 8'h5A;
    run_stream(1, 8'd254, 3, 1'b0, 1'b0, "wrap");
    check_eq("wrap_addr_after", im_addr_b, 8'd1);

    // random images
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        op_m[i]  = 7'($urandom_range(0, 127));
        lit_m[i] = 8'($urandom_range(0, 255));
      end
      run_stream(0, 8'd0, n, ($urandom_range(0, 3) == 0), k[0], "random");
      pulse_start();
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_drain_a", exp_q_a.size(), 0);
    check_eq("final_drain_b", exp_q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU's instruction memory: accepts a byte stream (valid/ready), assembles 15-bit instruction words {opcode[6:0], literal[7:0]} and writes them sequentially into instruction memory.
- Holds the CPU (PC/register clock gating or reset) via cpu_hold until a complete, checksum-verified image has been written.
- Sits between the host link and the instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory address width; matches the 8-bit PC.
- INSTR_W, 15, instruction word width: 7-bit opcode plus 8-bit literal.
- BASE_ADDR, 0, first instruction memory address written after each header.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid and in_ready are both high on a rising edge.
- in_data  in  8  input byte.
- start  in  1  single-cycle pulse; re-arms the loader from DONE or ERR.
- im_we  out  1  instruction memory write enable, one-cycle pulse.
- im_addr  out  ADDR_W  instruction memory write address.
- im_wdata  out  INSTR_W  instruction word {opcode, literal}.
- cpu_hold  out  1  high while the CPU must not execute.
- done  out  1  image loaded and verified.
- error  out  1  protocol or checksum failure.

Behaviour:
- Stream format: HDR byte N (instruction count, 1..255), then N pairs (HI, LO), then CSUM.
  - HI[7] must be 0; HI[6:0] is the opcode.
  - LO is the literal.
  - CSUM equals the XOR of HDR and every HI and LO byte.
- Reset values: state=S_HDR, in_ready=1, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_hold=1, done=0, error=0, xor accumulator=0, remaining count=0.
- States:
  - S_HDR: on accept, if N==0 go to S_ERR. Otherwise load count=N, acc=N, addr=BASE_ADDR, go to S_HI.
  - S_HI: on accept, if in_data[7]==1 go to S_ERR. Otherwise latch opcode, acc^=byte, go to S_LO.
  - S_LO: on accept, acc^=byte and count-=1. Next rising edge: im_we=1 for exactly one cycle, with im_wdata={opcode, byte} and im_addr=current address. The address increments after the write. Go to S_HI if count is still nonzero, else S_CSUM.
  - S_CSUM: on accept, if byte==acc go to S_DONE, else S_ERR.
  - S_DONE: done=1, cpu_hold=0, in_ready=0.
  - S_ERR: error=1, cpu_hold=1, in_ready=0.
- in_ready is 1 in S_HDR, S_HI, S_LO and S_CSUM. There are no bubbles: a byte can be accepted every cycle, and the im_we pulse overlaps acceptance of the next HI byte.
- Write latency: exactly 1 cycle from the LO handshake edge to im_we high.
- start:
  - In S_DONE or S_ERR: go to S_HDR, clear done and error, set cpu_hold=1, acc=0.
  - In any other state: ignored.
  - If start and in_valid occur in the same cycle in DONE or ERR: the byte is not accepted, because in_ready=0.
- Address arithmetic is modulo 2^ADDR_W. With BASE_ADDR+N > 256 the address wraps to 0; this is not an error.
- Words already written before an error remain in memory. The CPU stays held.
- Asynchronous reset mid-stream: returns immediately to the reset values, and an im_we in flight is dropped. The partial image is abandoned; the next byte is treated as HDR.
- in_valid low: state is held and no byte is consumed. in_data is don't-care.

Test Plan:
- Nominal load: HDR=0x02, HI=0x01, LO=0x05, HI=0x03, LO=0xA0, CSUM=0xA5 -> writes 0x0105 at address 0 and 0x03A0 at address 1, one cycle after each LO; then done=1, cpu_hold=0, in_ready=0.
- Bad checksum: same stream with CSUM=0xA4 -> both words written; error=1, done=0, cpu_hold=1.
- Illegal HI: HDR=0x01, HI=0x80 -> error=1, im_we never asserted; a start pulse returns to S_HDR with error=0.
- Back-to-back with gaps: the nominal stream with in_valid toggled every other cycle -> identical writes and final state; no extra im_we pulses.
- Reset mid-stream: rst_n low after the first LO byte but before the write edge -> no write occurs and all outputs return to reset values. A following nominal stream loads correctly from address BASE_ADDR.
- Zero count and wrap: HDR=0x00 -> error=1. With BASE_ADDR=254 and N=3 -> writes land at addresses 254, 255, 0, and done=1 with a correct CSUM.
